// File: rtl/alu_vector_driver.sv
// alu_vector_driver: applies host test vectors to the ALU, samples its result after a settle interval and reports pass/fail
module alu_vector_driver #(
    parameter int W      = 6,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [1:0]       vec_op,
    input  logic [W-1:0]     vec_a,
    input  logic [W-1:0]     vec_b,
    input  logic [W-1:0]     vec_exp,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [1:0]       alu_op,
    input  logic [W-1:0]     alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_pass,
    output logic [W-1:0]     res_got,
    output logic [CNT_W-1:0] res_idx,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             busy
);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_REPORT} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_t           state, state_nxt;
    logic [3:0]       cnt;
    logic [W-1:0]     exp_q;
    logic [CNT_W-1:0] idx;
    logic             accept, sample, match;

    // state register
    always_ff @(posedge clk) state <= rst ? S_IDLE : state_nxt;

    // next state and handshake strobes; unknown encodings fall back to idle
    always_comb begin
        state_nxt = state == S_IDLE   ? (vec_valid ? S_SETTLE : S_IDLE) :
                    state == S_SETTLE ? (cnt == '0 ? S_REPORT : S_SETTLE) :
                    state == S_REPORT ? (res_ready ? S_IDLE : S_REPORT) : S_IDLE;
        vec_ready = state == S_IDLE && !rst;
        busy      = state != S_IDLE;
        accept    = state == S_IDLE && vec_valid;
        sample    = state == S_SETTLE && cnt == '0;
        match     = alu_out == exp_q;
    end

    // operand registers, settle countdown, result record and saturating counters
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            exp_q     <= '0;
            cnt       <= '0;
            idx       <= '0;
            res_valid <= 1'b0;
            res_pass  <= 1'b0;
            res_got   <= '0;
            res_idx   <= '0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
        end else begin
            if (accept) begin
                alu_a  <= vec_a;
                alu_b  <= vec_b;
                alu_op <= vec_op;
                exp_q  <= vec_exp;
                cnt    <= 4'(SETTLE - 1);
            end
            if (state == S_SETTLE && cnt != '0)
                cnt <= cnt - 4'd1;
            if (sample) begin
                res_got   <= alu_out;
                res_pass  <= match;
                res_idx   <= idx;
                idx       <= idx + CNT_W'(1);
                res_valid <= 1'b1;
                if (match && pass_cnt != CNT_MAX)
                    pass_cnt <= pass_cnt + CNT_W'(1);
                if (!match && fail_cnt != CNT_MAX)
                    fail_cnt <= fail_cnt + CNT_W'(1);
            end
            if (state == S_REPORT && res_ready)
                res_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_vector_driver.sv
// tb_alu_vector_driver: directed vector table plus hand-written reset/backpressure/saturation sequences
module tb_alu_vector_driver;
    localparam int SETTLE = 2;
    typedef struct {
        logic [1:0] op;
        logic [5:0] a;
        logic [5:0] b;
        logic [5:0] e;
        logic [5:0] aout;
        logic       pass;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vec_valid = 1'b0;
    logic       vec_ready;
    logic [1:0] vec_op = '0;
    logic [5:0] vec_a = '0, vec_b = '0, vec_exp = '0;
    logic [5:0] alu_a, alu_b;
    logic [1:0] alu_op;
    logic [5:0] alu_out = '0;
    logic       res_valid, res_pass, busy;
    logic       res_ready = 1'b0;
    logic [5:0] res_got;
    logic [7:0] res_idx, pass_cnt, fail_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_acc = 0;
    int m_pass = 0, m_fail = 0, m_idx = 0;
    vec_t tv[8];

    alu_vector_driver #(.W(6), .SETTLE(SETTLE), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .vec_valid(vec_valid), .vec_ready(vec_ready),
        .vec_op(vec_op), .vec_a(vec_a), .vec_b(vec_b), .vec_exp(vec_exp),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_pass(res_pass), .res_got(res_got), .res_idx(res_idx),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at cycle %0d", name, got, want, cyc);
        end
    endtask

    // Called at a negedge; returns at the negedge after the result handshake.
    // If pend is set, nxt is presented on vec_* while the result is stalled and left asserted.
    task automatic apply(input vec_t v, input int stall, input bit pend, input vec_t nxt);
        int lat;
        vec_valid = 1'b1; vec_op = v.op; vec_a = v.a; vec_b = v.b; vec_exp = v.e; alu_out = v.aout;
        chk("accept_ready", vec_ready, 1);
        last_acc = cyc;
        @(negedge clk);
        vec_valid = 1'b0;
        chk("alu_op", alu_op, v.op);
        chk("alu_a", alu_a, v.a);
        chk("alu_b", alu_b, v.b);
        chk("settle_ready", vec_ready, 0);
        chk("settle_busy", busy, 1);
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, SETTLE);
        if (v.pass) m_pass = m_pass < 255 ? m_pass + 1 : 255;
        else m_fail = m_fail < 255 ? m_fail + 1 : 255;
        chk("res_pass", res_pass, v.pass);
        chk("res_got", res_got, v.aout);
        chk("res_idx", res_idx, m_idx);
        chk("pass_cnt", pass_cnt, m_pass);
        chk("fail_cnt", fail_cnt, m_fail);
        m_idx = (m_idx + 1) % 256;
        if (pend) begin
            vec_valid = 1'b1; vec_op = nxt.op; vec_a = nxt.a; vec_b = nxt.b; vec_exp = nxt.e;
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", res_valid, 1);
            chk("stall_got", res_got, v.aout);
            chk("stall_idx", res_idx, (m_idx + 255) % 256);
            chk("stall_ready", vec_ready, 0);
            chk("stall_alu_a", alu_a, v.a);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("done_valid", res_valid, 0);
        chk("done_ready", vec_ready, 1);
        chk("done_busy", busy, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vec_valid = 1'b0;
        @(negedge clk);
        chk("rst_ready", vec_ready, 0);
        chk("rst_valid", res_valid, 0);
        rst = 1'b0;
        m_pass = 0; m_fail = 0; m_idx = 0;
        @(negedge clk);
    endtask

    initial begin
        tv[0] = '{2'b01, 6'h0C, 6'h08, 6'h14, 6'h14, 1'b1};
        tv[1] = '{2'b11, 6'h37, 6'h02, 6'h09, 6'h37, 1'b0};
        tv[2] = '{2'b00, 6'h05, 6'h03, 6'h08, 6'h08, 1'b1};
        tv[3] = '{2'b10, 6'h3C, 6'h07, 6'h03, 6'h03, 1'b1};
        tv[4] = '{2'b00, 6'h1F, 6'h01, 6'h20, 6'h20, 1'b1};
        tv[5] = '{2'b01, 6'h20, 6'h01, 6'h1F, 6'h1E, 1'b0};
        tv[6] = '{2'b10, 6'h15, 6'h0A, 6'h00, 6'h00, 1'b1};
        tv[7] = '{2'b11, 6'h00, 6'h00, 6'h3F, 6'h1F, 1'b0};

        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("idle_ready", vec_ready, 1);
            chk("idle_busy", busy, 0);
            chk("idle_valid", res_valid, 0);
            chk("idle_cnts", {pass_cnt, fail_cnt}, 0);
            chk("idle_alu", {alu_op, alu_a, alu_b}, 0);
            @(negedge clk);
        end
        res_ready = 1'b0;

        apply(tv[0], 0, 1'b0, tv[0]);
        apply(tv[1], 0, 1'b0, tv[0]);

        vec_valid = 1'b1; vec_op = tv[2].op; vec_a = tv[2].a; vec_b = tv[2].b; vec_exp = tv[2].e;
        @(negedge clk);
        vec_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", vec_ready, 0);
        rst = 1'b0;
        m_pass = 0; m_fail = 0; m_idx = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_valid", res_valid, 0);
            chk("midrst_cnts", {pass_cnt, fail_cnt}, 0);
            chk("midrst_alu", {alu_op, alu_a, alu_b}, 0);
            chk("midrst_ready_after", vec_ready, 1);
        end

        apply(tv[2], 5, 1'b1, tv[3]);
        apply(tv[3], 0, 1'b0, tv[0]);

        do_reset();
        for (int i = 4; i < 8; i++) begin
            int prev;
            prev = last_acc;
            apply(tv[i], 0, 1'b0, tv[0]);
            if (i > 4) chk("stream_spacing", last_acc - prev, SETTLE + 2);
        end
        chk("stream_pass", pass_cnt, 2);
        chk("stream_fail", fail_cnt, 2);

        for (int i = 0; i < 256; i++) apply(tv[0], 0, 1'b0, tv[0]);
        chk("sat_pass", pass_cnt, 255);
        chk("sat_fail", fail_cnt, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_vector_driver.md
Name: alu_vector_driver

Overview:
- Sequential stimulus/response engine for the 6-bit signed ALU. It sits on the ALU's operand side and drives its A, B and Operator inputs.
- A host pushes test vectors {op, A, B, expected} over a valid/ready interface. The block applies each vector to the ALU, waits a settle interval, samples Out and compares it with the expected value.
- Results go back to the host over a second valid/ready interface. Running pass/fail counters are kept for the whole run.

Parameters:
- W, 6, operand/result width (matches ALU data width).
- SETTLE, 2, cycles between applying operands and sampling alu_out; legal range 1..15.
- CNT_W, 8, width of pass/fail counters and vector index.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- vec_valid  input  1  host has a vector on vec_*
- vec_ready  output  1  block can accept a vector this cycle
- vec_op  input  2  ALU operator code for this vector
- vec_a  input  W  signed operand A
- vec_b  input  W  signed operand B
- vec_exp  input  W  expected ALU result
- alu_a  output  W  registered operand A to ALU
- alu_b  output  W  registered operand B to ALU
- alu_op  output  2  registered operator to ALU
- alu_out  input  W  ALU result (combinational from alu_a/alu_b/alu_op)
- res_valid  output  1  result record valid
- res_ready  input  1  host accepts result record
- res_pass  output  1  1 = sampled alu_out equals vec_exp
- res_got  output  W  sampled alu_out
- res_idx  output  CNT_W  index of vector this result belongs to
- pass_cnt  output  CNT_W  number of passing vectors
- fail_cnt  output  CNT_W  number of failing vectors
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset values: all outputs 0 (vec_ready 0 during reset, 1 from the first cycle after reset deasserts); state IDLE; settle counter 0; vector index 0.
- FSM states: IDLE, SETTLE, REPORT.
- IDLE:
  - vec_ready=1.
  - On an edge with vec_valid=1, register vec_a/vec_b/vec_op into alu_a/alu_b/alu_op and vec_exp into an internal register.
  - Load the settle counter with SETTLE-1 and go to SETTLE. That edge is E0.
  - Without vec_valid, hold; alu_* keep their last values.
- SETTLE:
  - vec_ready=0.
  - Decrement the counter each edge.
  - On the edge where the counter is 0 (edge E0+SETTLE):
    - res_got <= alu_out.
    - res_pass <= (alu_out == exp), a full W-bit bitwise compare.
    - res_idx <= current index; index increments mod 2^CNT_W.
    - pass_cnt or fail_cnt increments.
    - res_valid <= 1; go to REPORT.
- REPORT:
  - res_valid held high; res_* stable until the handshake.
  - On an edge with res_ready=1: res_valid <= 0, go to IDLE.
  - res_ready while res_valid=0 is ignored.
- Latency: res_valid rises SETTLE cycles after the accept edge.
- Throughput with res_ready tied high: one vector per SETTLE+2 cycles (accept, SETTLE cycles, report handshake; the next accept comes the cycle after returning to IDLE).
- alu_* stay constant from E0 until the next accept; the ALU is never driven mid-settle.
- Counters saturate at 2^CNT_W-1 and do not wrap. res_idx wraps.
- Signedness does not affect the compare: equality only.
- Reset mid-operation: abandons any vector in flight, no result emitted, counters cleared, alu_* return to 0.
- vec_valid asserted in SETTLE/REPORT is not consumed; the host must hold it until vec_ready.

Test Plan:
- Reset then idle: after rst, vec_ready=1, busy=0, res_valid=0, counters 0, alu_*=0 -> all hold for 10 cycles with vec_valid=0.
- Single pass: push op=01, A=12, B=8, exp=20; bench drives alu_out=20 -> alu_op=01, alu_a=12, alu_b=8 one cycle after accept; res_valid rises exactly 2 cycles after accept edge; res_pass=1, res_got=20, res_idx=0; pass_cnt=1.
- Single fail, signed: push op=11, A=-9, B=2, exp=9; alu_out=-9 (6'b110111) -> res_pass=0, res_got=-9, fail_cnt=1, pass_cnt unchanged.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid -> res_* stable, vec_ready=0 throughout, the second pending vec_valid not accepted; release res_ready -> back to IDLE, second vector accepted the following cycle with res_idx=1.
- Reset mid-settle: accept a vector, assert rst on the cycle after accept -> no res_valid ever, counters 0, alu_*=0, vec_ready=1 after rst drops.
- Stream 4 vectors with res_ready=1 and SETTLE=2, mixed pass/fail (2/2) -> accepts spaced 4 cycles apart, res_idx 0..3, pass_cnt=2, fail_cnt=2.
